// File: rtl/target_addr_sequencer_pkg.sv
// Shared encodings for the target address sequencer: FSM states, result kinds,
// extender modes, SPARC op/op2 fields and the decode/condition helpers.
package target_addr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_CALC = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_CALL   = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_IMM    = 2'd3
    } kind_t;

    localparam logic [2:0] MODE_SIMM13 = 3'd0;
    localparam logic [2:0] MODE_SIMM11 = 3'd1;
    localparam logic [2:0] MODE_SIMM10 = 3'd2;
    localparam logic [2:0] MODE_DISP30 = 3'd3;
    localparam logic [2:0] MODE_IMM22  = 3'd4;
    localparam logic [2:0] MODE_DISP22 = 3'd5;

    localparam logic [1:0] OP_FMT2   = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [3:0] COND_BA = 4'b1000;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] mode;
    } decode_t;

    function automatic decode_t decode_ir(input logic [31:0] ir);
        decode_t d;
        d.kind = KIND_NONE;
        d.mode = MODE_SIMM13;
        if (ir[31:30] == OP_CALL) begin
            d.kind = KIND_CALL;
            d.mode = MODE_DISP30;
        end else if (ir[31:30] == OP_FMT2 && ir[24:22] == OP2_BICC) begin
            d.kind = KIND_BRANCH;
            d.mode = MODE_DISP22;
        end else if (ir[31:30] == OP_FMT2 && ir[24:22] == OP2_SETHI) begin
            d.kind = KIND_IMM;
            d.mode = MODE_IMM22;
        end else if (ir[31] && ir[13]) begin
            d.kind = KIND_IMM;
            d.mode = MODE_SIMM13;
        end
        return d;
    endfunction

    // icc is {N,Z,V,C}; cond[3] inverts the base test (BN/BA, BNE/BE, ...).
    function automatic logic branch_taken(input logic [3:0] cond, input logic [3:0] icc);
        logic n, z, v, c, base;
        n = icc[3];
        z = icc[2];
        v = icc[1];
        c = icc[0];
        case (cond[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = z;
            3'd2:    base = z | (n ^ v);
            3'd3:    base = n ^ v;
            3'd4:    base = c | z;
            3'd5:    base = c;
            3'd6:    base = n;
            default: base = v;
        endcase
        return base ^ cond[3];
    endfunction

endpackage

// File: rtl/target_addr_sequencer_sign_extender_magic_box.sv
// Immediate/displacement extender: turns instruction fields into a 32-bit
// operand according to the 3-bit mode chosen by decode.
module sign_extender_magic_box
    import target_addr_sequencer_pkg::*;
(
    input  logic [29:0] ir,
    input  logic [2:0]  mode,
    output logic [31:0] ext
);

    always_comb begin
        ext = '0;
        case (mode)
            MODE_SIMM13: ext = {{19{ir[12]}}, ir[12:0]};
            MODE_SIMM11: ext = {{21{ir[10]}}, ir[10:0]};
            MODE_SIMM10: ext = {{22{ir[9]}}, ir[9:0]};
            MODE_DISP30: ext = {ir[29:0], 2'b00};
            MODE_IMM22:  ext = {ir[21:0], 10'b0};
            MODE_DISP22: ext = {{8{ir[21]}}, ir[21:0], 2'b00};
            default:     ext = '0;
        endcase
    end

endmodule

// File: rtl/target_addr_sequencer.sv
// Four-state sequencer that captures an instruction, extends its immediate,
// computes the branch/call target or immediate value and offers the result.
module target_addr_sequencer
    import target_addr_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ir,
    input  logic [31:0] pc,
    input  logic [3:0]  icc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [31:0] out_value,
    output logic        out_taken,
    output logic        out_annul,
    output logic [15:0] xfer_count
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are
    // both high; valid never depends on ready, and the payload holds while valid
    // is high and ready is low. flush and reset cancel any transfer in progress.

    state_t      state;
    state_t      state_next;

    logic [31:0] ir_q;
    logic [31:0] pc_q;
    logic [3:0]  icc_q;
    logic [31:0] ext;
    logic [31:0] ext_q;
    decode_t     dec;

    kind_t       out_kind_q;
    logic [31:0] out_value_q;
    logic        out_taken_q;
    logic        out_annul_q;
    logic [15:0] count_q;

    kind_t       calc_kind;
    logic [31:0] calc_value;
    logic        calc_taken;
    logic        calc_annul;

    logic        accept;
    logic        deliver;

    assign in_ready  = (state == ST_IDLE) && !flush && !reset;
    assign out_valid = (state == ST_OUT);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready && !flush;

    assign dec = decode_ir(ir_q);

    sign_extender_magic_box u_ext (
        .ir   (ir_q[29:0]),
        .mode (dec.mode),
        .ext  (ext)
    );

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)  state_next = ST_EXT;
                ST_EXT:               state_next = ST_CALC;
                ST_CALC:              state_next = ST_OUT;
                ST_OUT:  if (deliver) state_next = ST_IDLE;
                default:              state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        calc_kind  = dec.kind;
        calc_value = '0;
        calc_taken = 1'b0;
        calc_annul = 1'b0;
        case (dec.kind)
            KIND_CALL: begin
                calc_value = pc_q + ext_q;
                calc_taken = 1'b1;
            end
            KIND_BRANCH: begin
                calc_value = pc_q + ext_q;
                calc_taken = branch_taken(ir_q[28:25], icc_q);
                // BA,a annuls its delay slot even though it is taken.
                calc_annul = ir_q[29] && (!calc_taken || ir_q[28:25] == COND_BA);
            end
            KIND_IMM: begin
                calc_value = ext_q;
            end
            default: begin
                calc_value = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ir_q        <= '0;
            pc_q        <= '0;
            icc_q       <= '0;
            ext_q       <= '0;
            out_kind_q  <= KIND_NONE;
            out_value_q <= '0;
            out_taken_q <= 1'b0;
            out_annul_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ir_q  <= ir;
                pc_q  <= pc;
                icc_q <= icc;
            end
            if (state == ST_EXT) begin
                ext_q <= ext;
            end
            if (state == ST_CALC && !flush) begin
                out_kind_q  <= calc_kind;
                out_value_q <= calc_value;
                out_taken_q <= calc_taken;
                out_annul_q <= calc_annul;
            end
            if (deliver && out_taken_q) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign out_kind   = out_kind_q;
    assign out_value  = out_value_q;
    assign out_taken  = out_taken_q;
    assign out_annul  = out_annul_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_target_addr_sequencer.sv
// Bench for target_addr_sequencer: directed vectors with literal expectations
// plus a per-cycle comparison against an instruction-level reference model.
module tb_target_addr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ir = '0;
    logic [31:0] pc = '0;
    logic [3:0]  icc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_kind;
    logic [31:0] out_value;
    logic        out_taken;
    logic        out_annul;
    logic [15:0] xfer_count;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] value;
        logic        taken;
        logic        annul;
    } res_t;

    target_addr_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ir         (ir),
        .pc         (pc),
        .icc        (icc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_value  (out_value),
        .out_taken  (out_taken),
        .out_annul  (out_annul),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result of one instruction straight from the ISA rules.
    function automatic res_t model_calc(input logic [31:0] w, input logic [31:0] a_pc,
                                        input logic [3:0] cc);
        res_t r;
        int   d;
        bit   n, z, v, c, base;
        r = '0;
        n = cc[3];
        z = cc[2];
        v = cc[1];
        c = cc[0];
        if (w[31:30] == 2'b01) begin
            r.kind  = 2'd1;
            r.value = a_pc + {w[29:0], 2'b00};
            r.taken = 1'b1;
        end else if (w[31:30] == 2'b00 && w[24:22] == 3'b010) begin
            d = int'(w[21:0]);
            if (w[21]) d = d - 4194304;
            r.kind  = 2'd2;
            r.value = a_pc + 32'(d * 4);
            case (w[27:25])
                3'd0: base = 1'b0;
                3'd1: base = z;
                3'd2: base = z || (n != v);
                3'd3: base = (n != v);
                3'd4: base = c || z;
                3'd5: base = c;
                3'd6: base = n;
                default: base = v;
            endcase
            r.taken = base ^ w[28];
            r.annul = w[29] && (!r.taken || w[28:25] == 4'b1000);
        end else if (w[31:30] == 2'b00 && w[24:22] == 3'b100) begin
            r.kind  = 2'd3;
            r.value = 32'(w[21:0]) * 32'd1024;
        end else if (w[31] && w[13]) begin
            d = int'(w[12:0]);
            if (w[12]) d = d - 8192;
            r.kind  = 2'd3;
            r.value = 32'(d);
        end
        return r;
    endfunction

    // Abstract model: phase 0 waiting, 1..2 working, 3 result offered.
    int          m_phase = 0;
    res_t        m_res = '0;
    logic [15:0] m_count = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_count = '0;
        end else if (flush) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   = model_calc(ir, pc, icc);
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: m_phase = 3;
                default: if (out_ready) begin
                    if (m_res.taken) m_count = m_count + 16'd1;
                    m_phase = 0;
                end
            endcase
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready", 32'(in_ready), 32'(m_phase == 0 && !flush && !reset));
            check("cmp_out_valid", 32'(out_valid), 32'(m_phase == 3));
            check("cmp_xfer_count", 32'(xfer_count), 32'(m_count));
            if (m_phase == 3) begin
                check("cmp_out_kind", 32'(out_kind), 32'(m_res.kind));
                check("cmp_out_value", out_value, m_res.value);
                check("cmp_out_taken", 32'(out_taken), 32'(m_res.taken));
                check("cmp_out_annul", 32'(out_annul), 32'(m_res.annul));
            end
        end
    end

    // Offer one instruction and return just after the accepting edge.
    task automatic offer(input logic [31:0] w, input logic [31:0] a_pc, input logic [3:0] cc);
        int k;
        ir = w;
        pc = a_pc;
        icc = cc;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid; returns cycles spent after the accepting edge.
    task automatic wait_out(output int k);
        k = 0;
        while (!out_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] w, input logic [31:0] a_pc,
                           input logic [3:0] cc, input logic [1:0] e_kind,
                           input logic [31:0] e_value, input logic e_taken, input logic e_annul);
        int k;
        offer(w, a_pc, cc);
        wait_out(k);
        check({tag, "_latency"}, 32'(k), 32'd2);
        check({tag, "_kind"}, 32'(out_kind), 32'(e_kind));
        check({tag, "_value"}, out_value, e_value);
        check({tag, "_taken"}, 32'(out_taken), 32'(e_taken));
        check({tag, "_annul"}, 32'(out_annul), 32'(e_annul));
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_model_only(input logic [31:0] w, input logic [31:0] a_pc,
                                   input logic [3:0] cc);
        int k;
        offer(w, a_pc, cc);
        wait_out(k);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] icc_tab [4] = '{4'b0000, 4'b1111, 4'b0100, 4'b1010};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_kind", 32'(out_kind), 32'd0);
        check("rst_out_value", out_value, 32'd0);
        check("rst_out_taken", 32'(out_taken), 32'd0);
        check("rst_out_annul", 32'(out_annul), 32'd0);
        check("rst_xfer_count", 32'(xfer_count), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        run_vec("call", 32'h40000004, 32'h00001000, 4'b0000, 2'd1, 32'h00001010, 1'b1, 1'b0);
        run_vec("bne_z0", 32'h12BFFFFE, 32'h00002000, 4'b0000, 2'd2, 32'h00001FF8, 1'b1, 1'b0);
        run_vec("bne_z1", 32'h12BFFFFE, 32'h00002000, 4'b0100, 2'd2, 32'h00001FF8, 1'b0, 1'b0);
        check("pre_ba_xfer", 32'(xfer_count), 32'd2);
        run_vec("ba_a", 32'h30800001, 32'h00000100, 4'b0000, 2'd2, 32'h00000104, 1'b1, 1'b1);
        check("ba_a_xfer", 32'(xfer_count), 32'd3);
        run_vec("sethi", 32'h01012345, 32'h00000000, 4'b0000, 2'd3, 32'h048D1400, 1'b0, 1'b0);
        run_vec("simm13", 32'h80003FFF, 32'h00000040, 4'b0000, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_vec("none_unimp", 32'h00000000, 32'h00000040, 4'b0000, 2'd0, 32'h00000000, 1'b0, 1'b0);
        run_vec("none_reg", 32'h80000001, 32'h00000040, 4'b1111, 2'd0, 32'h00000000, 1'b0, 1'b0);

        // Back-pressure: result must sit unchanged while out_ready is low.
        out_ready = 1'b0;
        run_vec("bp", 32'h40000004, 32'h00001000, 4'b0000, 2'd1, 32'h00001010, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_value", out_value, 32'h00001010);
            check("bp_hold_kind", 32'(out_kind), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_done_valid", 32'(out_valid), 32'd0);
        check("bp_xfer", 32'(xfer_count), 32'd4);

        // Flush while in CALC.
        offer(32'h40000004, 32'h00001000, 4'b0000);
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("flush_no_pulse", 32'(out_valid), 32'd0);
        end
        check("flush_xfer", 32'(xfer_count), 32'd4);

        // Flush beats in_valid in IDLE.
        ir = 32'h40000004;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("flush_idle_no_accept", 32'(out_valid), 32'd0);
        end

        // Reset while in EXT.
        offer(32'h30800001, 32'h00000100, 4'b0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ext_in_ready", 32'(in_ready), 32'd0);
        check("rst_ext_out_valid", 32'(out_valid), 32'd0);
        check("rst_ext_kind", 32'(out_kind), 32'd0);
        check("rst_ext_value", out_value, 32'd0);
        check("rst_ext_taken", 32'(out_taken), 32'd0);
        check("rst_ext_annul", 32'(out_annul), 32'd0);
        check("rst_ext_xfer", 32'(xfer_count), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ext_ready_after", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rst_ext_no_pulse", 32'(out_valid), 32'd0);
        end

        // Flush while a taken result waits in OUT with out_ready high: not delivered.
        out_ready = 1'b0;
        run_vec("flush_out", 32'h40000004, 32'h00001000, 4'b0000, 2'd1, 32'h00001010, 1'b1, 1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_xfer", 32'(xfer_count), 32'd0);

        // Every condition code against several flag patterns, annul on odd cond.
        for (int cnd = 0; cnd < 16; cnd++) begin
            for (int j = 0; j < 4; j++) begin
                send_model_only({2'b00, 1'(cnd % 2), 4'(cnd), 3'b010, 22'(32'h3FFFF0 + 32'(j))},
                                32'h00400000 + 32'(cnd * 64), icc_tab[j]);
            end
        end
        check("sweep_xfer_nonzero", 32'(xfer_count != 16'd0), 32'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
